// File: rtl/sfu_fp_pkg.sv
// Shared float32 helpers for the SFU adder path: constants, the unpacked-operand record and the unpack function.
// SFU_ALIGN_DENORM_EN selects subnormal support; when undefined, subnormals are flushed to signed zero.
package sfu_fp_pkg;

  localparam int ALIGN_W = 28;
  localparam logic [31:0] QNAN_32 = 32'h7FC0_0000;
  localparam logic [31:0] INF_32  = 32'h7F80_0000;

  typedef struct packed {
    logic               sign;
    logic [7:0]         exp;
    logic [ALIGN_W-1:0] mant;
    logic               is_nan;
    logic               is_inf;
    logic               is_zero;
  } fp_unpacked_t;

  // flip inverts the sign so the subtrahend can be treated as an addend
  function automatic fp_unpacked_t unpack_f32(input logic [31:0] x, input logic flip);
    fp_unpacked_t u;
    logic [7:0]  e;
    logic [22:0] f;
    e = x[30:23];
    f = x[22:0];
    u.sign   = x[31] ^ flip;
    u.is_nan = (&e) & (|f);
    u.is_inf = (&e) & ~(|f);
    if (e == 8'd0) begin
`ifdef SFU_ALIGN_DENORM_EN
      u.exp     = {7'd0, |f};
      u.mant    = {2'b00, f, 3'b000};
      u.is_zero = ~(|f);
`else
      u.exp     = 8'd0;
      u.mant    = '0;
      u.is_zero = 1'b1;
`endif
    end else begin
      u.exp     = e;
      u.mant    = {2'b01, f, 3'b000};
      u.is_zero = 1'b0;
    end
    return u;
  endfunction

endpackage

// File: rtl/align_rshift_sticky.sv
// Combinational right shifter that ORs every shifted-out bit into bit 0 and saturates
// large shift counts to a lone sticky bit.
module align_rshift_sticky #(
  parameter int W    = 28,
  parameter int SH_W = 8
) (
  input  logic [W-1:0]    din,
  input  logic [SH_W-1:0] shamt,
  output logic [W-1:0]    dout
);

  logic [W-1:0] lost;
  logic         sat;

  // bit gi falls off the end when the shift count exceeds its position
  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_lost
      assign lost[gi] = din[gi] & (shamt > SH_W'(gi));
    end
  endgenerate

  assign sat = (shamt >= SH_W'(W - 1));

  always_comb begin
    if (sat) begin
      dout = {{(W-1){1'b0}}, |din};
    end else begin
      dout = (din >> shamt) | {{(W-1){1'b0}}, |lost};
    end
  end

endmodule

// File: rtl/fp_align_float_32.sv
// Two-stage valid/ready float32 alignment stage feeding the LZA: unpack/compare/swap, then shift/complement.
// SFU_ALIGN_DENORM_EN (see sfu_fp_pkg) enables subnormal inputs; default flushes them to signed zero.
module fp_align_float_32
  import sfu_fp_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MANT_WIDTH = 23,
  parameter int EXP_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_a,
  output logic [WIDTH-1:0]     out_b,
  output logic                 out_c_in,
  output logic [EXP_WIDTH-1:0] out_exp,
  output logic                 out_sign,
  output logic                 out_swap,
  output logic                 out_special,
  output logic [WIDTH-1:0]     out_special_val
);

  localparam int AW = MANT_WIDTH + 5;

  fp_unpacked_t         ua, ub;
  logic                 eff_sub_next, swap_next, cancel_next, sign_next;
  logic                 nan_next, special_next;
  logic [WIDTH-1:0]     special_val_next;
  logic [AW-1:0]        mant_large_next, mant_small_next;
  logic [EXP_WIDTH-1:0] exp_large_next, d_next;

  logic                 s1_valid_reg;
  logic [AW-1:0]        s1_mant_large_reg, s1_mant_small_reg;
  logic [EXP_WIDTH-1:0] s1_exp_reg, s1_d_reg;
  logic                 s1_eff_sub_reg, s1_sign_reg, s1_swap_reg, s1_special_reg;
  logic [WIDTH-1:0]     s1_special_val_reg;

  logic                 s2_adv;
  logic [AW-1:0]        b_al;
  logic [WIDTH-1:0]     b_ext;

  assign s2_adv   = out_ready | ~out_valid;
  assign in_ready = ~s1_valid_reg | s2_adv;

  always_comb begin
    ua = unpack_f32(in_a, 1'b0);
    ub = unpack_f32(in_b, in_sub);
    eff_sub_next = ua.sign ^ ub.sign;
    swap_next    = (ub.exp > ua.exp) || ((ub.exp == ua.exp) && (ub.mant > ua.mant));
    mant_large_next = swap_next ? ub.mant : ua.mant;
    mant_small_next = swap_next ? ua.mant : ub.mant;
    exp_large_next  = swap_next ? ub.exp : ua.exp;
    d_next          = swap_next ? (ub.exp - ua.exp) : (ua.exp - ub.exp);
    // equal magnitudes under subtraction cancel exactly to +0
    cancel_next = eff_sub_next &
                  ((ua.is_zero & ub.is_zero) | ((ua.exp == ub.exp) && (ua.mant == ub.mant)));
    nan_next     = ua.is_nan | ub.is_nan | (ua.is_inf & ub.is_inf & eff_sub_next);
    special_next = nan_next | ua.is_inf | ub.is_inf;
    special_val_next = '0;
    if (nan_next) begin
      special_val_next = QNAN_32;
    end else if (ua.is_inf) begin
      special_val_next = {ua.sign, INF_32[30:0]};
    end else if (ub.is_inf) begin
      special_val_next = {ub.sign, INF_32[30:0]};
    end
    sign_next = cancel_next ? 1'b0 : (swap_next ? ub.sign : ua.sign);
    if (special_next) begin
      sign_next = special_val_next[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg       <= 1'b0;
      s1_mant_large_reg  <= '0;
      s1_mant_small_reg  <= '0;
      s1_exp_reg         <= '0;
      s1_d_reg           <= '0;
      s1_eff_sub_reg     <= 1'b0;
      s1_sign_reg        <= 1'b0;
      s1_swap_reg        <= 1'b0;
      s1_special_reg     <= 1'b0;
      s1_special_val_reg <= '0;
    end else if (in_ready) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_mant_large_reg  <= mant_large_next;
        s1_mant_small_reg  <= mant_small_next;
        s1_exp_reg         <= exp_large_next;
        s1_d_reg           <= d_next;
        s1_eff_sub_reg     <= eff_sub_next;
        s1_sign_reg        <= sign_next;
        s1_swap_reg        <= swap_next;
        s1_special_reg     <= special_next;
        s1_special_val_reg <= special_val_next;
      end
    end
  end

  align_rshift_sticky #(.W(AW), .SH_W(EXP_WIDTH)) u_rshift (
    .din   (s1_mant_small_reg),
    .shamt (s1_d_reg),
    .dout  (b_al)
  );

  assign b_ext = {{(WIDTH-AW){1'b0}}, b_al};

  // specials zero the mantissa path so the adder sees a harmless 0 + 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid       <= 1'b0;
      out_a           <= '0;
      out_b           <= '0;
      out_c_in        <= 1'b0;
      out_exp         <= '0;
      out_sign        <= 1'b0;
      out_swap        <= 1'b0;
      out_special     <= 1'b0;
      out_special_val <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid_reg;
      if (s1_valid_reg) begin
        out_a           <= s1_special_reg ? '0 : {{(WIDTH-AW){1'b0}}, s1_mant_large_reg};
        out_b           <= s1_special_reg ? '0 : (s1_eff_sub_reg ? ~b_ext : b_ext);
        out_c_in        <= s1_eff_sub_reg & ~s1_special_reg;
        out_exp         <= s1_exp_reg;
        out_sign        <= s1_sign_reg;
        out_swap        <= s1_swap_reg;
        out_special     <= s1_special_reg;
        out_special_val <= s1_special_reg ? s1_special_val_reg : '0;
      end
    end
  end

endmodule
